// File: rtl/cfu_ctx_sequencer.sv
// cfu_ctx_sequencer: saves or restores one CFU state context
// over CFU-L2 using the standard state CFIDs and a context RAM.

package cfu_ctx_pkg;

    typedef enum logic [2:0] {
        CFU_OK           = 3'd0,
        CFU_ERROR_CFU    = 3'd1,
        CFU_ERROR_OFF    = 3'd2,
        CFU_ERROR_STATE  = 3'd3,
        CFU_ERROR_CUSTOM = 3'd4
    } cfu_status_t;

    // Context status word as carried in bits [31:0] of a data word.
    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [9:0]  state_size;
        logic [3:0]  rsvd_lo;
        logic [1:0]  cs;
    } csw_t;

    localparam int CSW_SIZE_LSB = 6;

    localparam int CFID_WRITE_STATE  = 1020;
    localparam int CFID_READ_STATE   = 1021;
    localparam int CFID_WRITE_STATUS = 1022;
    localparam int CFID_READ_STATUS  = 1023;

endpackage

module cfu_ctx_sequencer
    import cfu_ctx_pkg::*;
#(
    parameter int CFU_N_CFUS     = 4,
    parameter int CFU_N_STATES   = 4,
    parameter int CFU_FUNC_ID_W  = 10,
    parameter int CFU_INSN_W     = 32,
    parameter int CFU_DATA_W     = 32,
    parameter int MEM_ADDR_W     = 10,
    parameter int CFU_CFU_ID_W   = $clog2(CFU_N_CFUS),
    parameter int CFU_STATE_ID_W = $clog2(CFU_N_STATES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_en,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_save,
    input  logic [CFU_CFU_ID_W-1:0]   cmd_cfu,
    input  logic [CFU_STATE_ID_W-1:0] cmd_state,
    input  logic [MEM_ADDR_W-1:0]     cmd_addr,
    output logic                      done_valid,
    output cfu_status_t               done_status,
    output logic [10:0]               done_count,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic [CFU_CFU_ID_W-1:0]   req_cfu,
    output logic [CFU_STATE_ID_W-1:0] req_state,
    output logic [CFU_FUNC_ID_W-1:0]  req_func,
    output logic [CFU_INSN_W-1:0]     req_insn,
    output logic [CFU_DATA_W-1:0]     req_data0,
    output logic [CFU_DATA_W-1:0]     req_data1,
    input  logic                      resp_valid,
    output logic                      resp_ready,
    input  cfu_status_t               resp_status,
    input  logic [CFU_DATA_W-1:0]     resp_data,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_ADDR_W-1:0]     mem_addr,
    output logic [CFU_DATA_W-1:0]     mem_wdata,
    input  logic [CFU_DATA_W-1:0]     mem_rdata
);

    localparam logic [CFU_FUNC_ID_W-1:0] F_WR_STATE =
        CFU_FUNC_ID_W'(CFID_WRITE_STATE);
    localparam logic [CFU_FUNC_ID_W-1:0] F_RD_STATE =
        CFU_FUNC_ID_W'(CFID_READ_STATE);
    localparam logic [CFU_FUNC_ID_W-1:0] F_WR_STATUS =
        CFU_FUNC_ID_W'(CFID_WRITE_STATUS);
    localparam logic [CFU_FUNC_ID_W-1:0] F_RD_STATUS =
        CFU_FUNC_ID_W'(CFID_READ_STATUS);

    typedef enum logic [3:0] {
        IDLE,
        S_RDSTAT,
        S_WSTAT,
        S_WRCSW,
        S_RDWORD,
        S_WWORD,
        S_WRWORD,
        R_RDCSW,
        R_LDCSW,
        R_RDWORD,
        R_LDWORD,
        R_WRWORD,
        R_WWORD,
        R_WRSTAT,
        R_WSTAT,
        DONE
    } state_t;

    state_t                    state_q, state_n;
    logic [CFU_CFU_ID_W-1:0]   cfu_q, cfu_n;
    logic [CFU_STATE_ID_W-1:0] st_q, st_n;
    logic [MEM_ADDR_W-1:0]     addr_q, addr_n;
    logic [9:0]                n_q, n_n;
    logic [9:0]                i_q, i_n;
    logic [10:0]               cnt_q, cnt_n;
    cfu_status_t               status_q, status_n;
    logic [CFU_DATA_W-1:0]     data_q, data_n;
    csw_t                      csw_q, csw_n;

    logic [MEM_ADDR_W-1:0]     word_addr;
    logic                      i_last;

    assign req_cfu   = cfu_q;
    assign req_state = st_q;
    assign req_insn  = '0;
    assign req_data1 = '0;

    assign word_addr = addr_q + MEM_ADDR_W'(i_q) + MEM_ADDR_W'(1);
    assign i_last    = ({1'b0, i_q} + 11'd1) == {1'b0, n_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cfu_q    <= '0;
            st_q     <= '0;
            addr_q   <= '0;
            n_q      <= '0;
            i_q      <= '0;
            cnt_q    <= '0;
            status_q <= CFU_OK;
            data_q   <= '0;
            csw_q    <= '0;
        end else if (clk_en) begin
            state_q  <= state_n;
            cfu_q    <= cfu_n;
            st_q     <= st_n;
            addr_q   <= addr_n;
            n_q      <= n_n;
            i_q      <= i_n;
            cnt_q    <= cnt_n;
            status_q <= status_n;
            data_q   <= data_n;
            csw_q    <= csw_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        cfu_n       = cfu_q;
        st_n        = st_q;
        addr_n      = addr_q;
        n_n         = n_q;
        i_n         = i_q;
        cnt_n       = cnt_q;
        status_n    = status_q;
        data_n      = data_q;
        csw_n       = csw_q;
        cmd_ready   = 1'b0;
        req_valid   = 1'b0;
        req_func    = '0;
        req_data0   = '0;
        resp_ready  = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        done_valid  = 1'b0;
        done_status = CFU_OK;
        done_count  = '0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cfu_n    = cmd_cfu;
                    st_n     = cmd_state;
                    addr_n   = cmd_addr;
                    i_n      = '0;
                    cnt_n    = '0;
                    status_n = CFU_OK;
                    state_n  = cmd_save ? S_RDSTAT : R_RDCSW;
                end
            end
            S_RDSTAT: begin
                req_valid = 1'b1;
                req_func  = F_RD_STATUS;
                if (req_ready) state_n = S_WSTAT;
            end
            S_WSTAT: begin
                resp_ready = 1'b1;
                if (resp_valid) begin
                    if (resp_status != CFU_OK) begin
                        status_n = resp_status;
                        state_n  = DONE;
                    end else begin
                        data_n       = '0;
                        data_n[31:0] = resp_data[31:0];
                        n_n          = resp_data[CSW_SIZE_LSB +: 10];
                        state_n      = S_WRCSW;
                    end
                end
            end
            S_WRCSW: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = data_q;
                cnt_n     = cnt_q + 11'd1;
                state_n   = (n_q == '0) ? DONE : S_RDWORD;
            end
            S_RDWORD: begin
                req_valid = 1'b1;
                req_func  = F_RD_STATE;
                req_data0 = CFU_DATA_W'(i_q);
                if (req_ready) state_n = S_WWORD;
            end
            S_WWORD: begin
                resp_ready = 1'b1;
                if (resp_valid) begin
                    if (resp_status != CFU_OK) begin
                        status_n = resp_status;
                        state_n  = DONE;
                    end else begin
                        data_n  = resp_data;
                        state_n = S_WRWORD;
                    end
                end
            end
            S_WRWORD: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = data_q;
                cnt_n     = cnt_q + 11'd1;
                i_n       = i_q + 10'd1;
                state_n   = i_last ? DONE : S_RDWORD;
            end
            R_RDCSW: begin
                mem_en   = 1'b1;
                mem_addr = addr_q;
                state_n  = R_LDCSW;
            end
            // RAM data arrives one cycle after the read is issued.
            R_LDCSW: begin
                csw_n   = mem_rdata[31:0];
                n_n     = mem_rdata[CSW_SIZE_LSB +: 10];
                state_n = (mem_rdata[CSW_SIZE_LSB +: 10] == '0)
                        ? R_WRSTAT : R_RDWORD;
            end
            R_RDWORD: begin
                mem_en   = 1'b1;
                mem_addr = word_addr;
                state_n  = R_LDWORD;
            end
            R_LDWORD: begin
                data_n  = mem_rdata;
                state_n = R_WRWORD;
            end
            R_WRWORD: begin
                req_valid = 1'b1;
                req_func  = F_WR_STATE;
                req_data0 = data_q;
                if (req_ready) state_n = R_WWORD;
            end
            R_WWORD: begin
                resp_ready = 1'b1;
                if (resp_valid) begin
                    if (resp_status != CFU_OK) begin
                        status_n = resp_status;
                        state_n  = DONE;
                    end else begin
                        cnt_n   = cnt_q + 11'd1;
                        i_n     = i_q + 10'd1;
                        state_n = i_last ? R_WRSTAT : R_RDWORD;
                    end
                end
            end
            R_WRSTAT: begin
                req_valid       = 1'b1;
                req_func        = F_WR_STATUS;
                req_data0[31:0] = csw_q;
                if (req_ready) state_n = R_WSTAT;
            end
            R_WSTAT: begin
                resp_ready = 1'b1;
                if (resp_valid) begin
                    status_n = resp_status;
                    if (resp_status == CFU_OK) cnt_n = cnt_q + 11'd1;
                    state_n = DONE;
                end
            end
            DONE: begin
                done_valid  = 1'b1;
                done_status = status_q;
                done_count  = cnt_q;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cfu_ctx_sequencer.sv
// tb_cfu_ctx_sequencer: directed save/restore scenarios against
// a scripted CFU responder and a behavioural context RAM.

module tb_cfu_ctx_sequencer;
    import cfu_ctx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_save;
    logic [1:0]  cmd_cfu;
    logic [1:0]  cmd_state;
    logic [9:0]  cmd_addr;
    logic        done_valid;
    cfu_status_t done_status;
    logic [10:0] done_count;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_cfu;
    logic [1:0]  req_state;
    logic [9:0]  req_func;
    logic [31:0] req_insn;
    logic [31:0] req_data0;
    logic [31:0] req_data1;
    logic        resp_valid;
    logic        resp_ready;
    cfu_status_t resp_status;
    logic [31:0] resp_data;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    cfu_ctx_sequencer dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_save(cmd_save), .cmd_cfu(cmd_cfu),
        .cmd_state(cmd_state), .cmd_addr(cmd_addr),
        .done_valid(done_valid), .done_status(done_status),
        .done_count(done_count),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cfu(req_cfu), .req_state(req_state),
        .req_func(req_func), .req_insn(req_insn),
        .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_status(resp_status), .resp_data(resp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ram [1024];
    logic [45:0] log_q [$];
    logic [45:0] exp_q [$];
    cfu_status_t rsp_st_q [$];
    logic [31:0] rsp_d_q [$];
    int rsp_idx    = 0;
    int rdy_delay  = 0;
    int rsp_delay  = 0;
    int mem_wr_cnt = 0;
    int stab_err   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [109:0] req_snap();
        return {req_cfu, req_state, req_func, req_data0, req_data1, req_insn};
    endfunction

    function automatic logic [45:0] rq(input logic [1:0] c,
                                       input logic [1:0] s,
                                       input int f,
                                       input logic [31:0] d);
        return {c, s, f[9:0], d};
    endfunction

    // Context RAM: one-cycle read latency, frozen with clk_en.
    initial begin
        for (int k = 0; k < 1024; k++) ram[k] = 32'hDEAD0000 | k;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (clk_en && mem_en) begin
                if (mem_we) ram[mem_addr] = mem_wdata;
                else mem_rdata <= ram[mem_addr];
            end
        end
    end

    // CFU responder, request log and handshake stability monitor.
    initial begin
        bit          pending;
        bit          prev_hold;
        int          rdy_wait;
        int          rsp_wait;
        logic [109:0] snap;
        pending = 0; prev_hold = 0; rdy_wait = 0; rsp_wait = 0; snap = '0;
        req_ready = 0; resp_valid = 0; resp_status = CFU_OK; resp_data = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                pending = 0; prev_hold = 0; rdy_wait = rdy_delay;
                #1;
                req_ready = 0; resp_valid = 0;
                resp_status = CFU_OK; resp_data = '0;
            end else begin
                if (clk_en) begin
                    if (mem_en && mem_we) mem_wr_cnt++;
                    if (prev_hold && (!req_valid || req_snap() != snap))
                        stab_err++;
                    prev_hold = req_valid && !req_ready;
                    snap = req_snap();
                    if (resp_valid && resp_ready) begin
                        pending = 0;
                        rsp_idx++;
                    end
                    if (req_valid && req_ready) begin
                        log_q.push_back({req_cfu, req_state, req_func, req_data0});
                        pending = 1;
                        rsp_wait = rsp_delay;
                        rdy_wait = rdy_delay;
                    end
                end
                #1;
                if (req_valid && !pending) begin
                    if (rdy_wait == 0) req_ready = 1;
                    else begin
                        rdy_wait--;
                        req_ready = 0;
                    end
                end else begin
                    req_ready = 0;
                    rdy_wait = rdy_delay;
                end
                if (pending && rsp_wait == 0) begin
                    resp_valid = 1;
                    if (rsp_idx < rsp_st_q.size()) begin
                        resp_status = rsp_st_q[rsp_idx];
                        resp_data = rsp_d_q[rsp_idx];
                    end else begin
                        resp_status = CFU_OK;
                        resp_data = '0;
                    end
                end else begin
                    if (pending) rsp_wait--;
                    resp_valid = 0;
                    resp_status = CFU_OK;
                    resp_data = '0;
                end
            end
        end
    end

    task automatic arm();
        log_q.delete();
        exp_q.delete();
        rsp_st_q.delete();
        rsp_d_q.delete();
        rsp_idx = 0;
        stab_err = 0;
    endtask

    task automatic rsp(input cfu_status_t s, input logic [31:0] d);
        rsp_st_q.push_back(s);
        rsp_d_q.push_back(d);
    endtask

    task automatic send_cmd(input bit sv, input logic [1:0] c,
                            input logic [1:0] s, input logic [9:0] a);
        @(negedge clk);
        cmd_valid = 1; cmd_save = sv;
        cmd_cfu = c; cmd_state = s; cmd_addr = a;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_done(input string tag, output cfu_status_t st,
                             output logic [10:0] cnt);
        bit got;
        got = 0;
        st = CFU_OK;
        cnt = '0;
        for (int k = 0; k < 3000 && !got; k++) begin
            if (done_valid) begin
                got = 1;
                st = done_status;
                cnt = done_count;
            end else @(negedge clk);
        end
        check({tag, "_done"}, 64'(got), 64'd1);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_nreq"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < log_q.size(); k++)
            check($sformatf("%s_req%0d", tag, k), 64'(log_q[k]), 64'(exp_q[k]));
    endtask

    task automatic check_ram4(input string tag, input logic [9:0] base,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] ev [4];
        logic [9:0]  a;
        ev = '{e0, e1, e2, e3};
        for (int k = 0; k < 4; k++) begin
            a = base + 10'(k);
            check($sformatf("%s_mem%0d", tag, k), 64'(ram[a]), 64'(ev[k]));
        end
    endtask

    task automatic script_n3();
        rsp(CFU_OK, 32'h000000C3);
        rsp(CFU_OK, 32'hA);
        rsp(CFU_OK, 32'hB);
        rsp(CFU_OK, 32'hC);
    endtask

    task automatic exp_save_n3(input logic [1:0] c, input logic [1:0] s);
        exp_q.push_back(rq(c, s, 1023, 0));
        exp_q.push_back(rq(c, s, 1021, 0));
        exp_q.push_back(rq(c, s, 1021, 1));
        exp_q.push_back(rq(c, s, 1021, 2));
    endtask

    task automatic exp_restore_n3(input logic [1:0] c, input logic [1:0] s);
        exp_q.push_back(rq(c, s, 1020, 32'hA));
        exp_q.push_back(rq(c, s, 1020, 32'hB));
        exp_q.push_back(rq(c, s, 1020, 32'hC));
        exp_q.push_back(rq(c, s, 1022, 32'hC3));
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_rdy"}, 64'(cmd_ready), 64'd1);
        check({tag, "_ctl"},
              64'({req_valid, resp_ready, mem_en, mem_we, done_valid}), 64'd0);
        check({tag, "_val"},
              64'({req_cfu, req_state, req_func, mem_addr, done_count,
                   done_status}), 64'd0);
        check({tag, "_dat"}, {req_data0, mem_wdata}, 64'd0);
    endtask

    initial begin
        cfu_status_t st;
        logic [10:0] cnt;
        logic [63:0] frz;
        int          wr0;
        rst_n = 0; clk_en = 1; cmd_valid = 0; cmd_save = 0;
        cmd_cfu = '0; cmd_state = '0; cmd_addr = '0;
        repeat (3) @(negedge clk);
        check_idle_outs("rst");
        rst_n = 1;

        // Save N=3, CFU 1 state 2 at 0x10
        arm(); script_n3(); exp_save_n3(2'd1, 2'd2);
        send_cmd(1, 2'd1, 2'd2, 10'h10);
        wait_done("save", st, cnt);
        check("save_st", 64'(st), 64'(CFU_OK));
        check("save_cnt", 64'(cnt), 64'd4);
        check_log("save");
        check_ram4("save", 10'h10, 32'hC3, 32'hA, 32'hB, 32'hC);

        // Restore the same image
        arm();
        repeat (4) rsp(CFU_OK, 32'h0);
        exp_restore_n3(2'd1, 2'd2);
        wr0 = mem_wr_cnt;
        send_cmd(0, 2'd1, 2'd2, 10'h10);
        wait_done("rest", st, cnt);
        check("rest_st", 64'(st), 64'(CFU_OK));
        check("rest_cnt", 64'(cnt), 64'd4);
        check("rest_nowr", 64'(mem_wr_cnt - wr0), 64'd0);
        check_log("rest");

        // Save with an empty context
        arm();
        rsp(CFU_OK, 32'h00000003);
        exp_q.push_back(rq(2'd2, 2'd0, 1023, 0));
        send_cmd(1, 2'd2, 2'd0, 10'h40);
        wait_done("n0", st, cnt);
        check("n0_st", 64'(st), 64'(CFU_OK));
        check("n0_cnt", 64'(cnt), 64'd1);
        check_log("n0");
        check("n0_csw", 64'(ram[10'h40]), 64'h3);
        check("n0_next", 64'(ram[10'h41]), 64'hDEAD0041);

        // Backpressure on both channels
        arm(); script_n3(); exp_save_n3(2'd3, 2'd1);
        rdy_delay = 5; rsp_delay = 7;
        send_cmd(1, 2'd3, 2'd1, 10'h20);
        wait_done("bp", st, cnt);
        rdy_delay = 0; rsp_delay = 0;
        check("bp_st", 64'(st), 64'(CFU_OK));
        check("bp_cnt", 64'(cnt), 64'd4);
        check("bp_stable", 64'(stab_err), 64'd0);
        check_log("bp");
        check_ram4("bp", 10'h20, 32'hC3, 32'hA, 32'hB, 32'hC);

        // Clock enable held low while a response is offered
        arm();
        rsp(CFU_OK, 32'h00000043);
        rsp(CFU_OK, 32'h77);
        exp_q.push_back(rq(2'd0, 2'd3, 1023, 0));
        exp_q.push_back(rq(2'd0, 2'd3, 1021, 0));
        fork
            begin
                send_cmd(1, 2'd0, 2'd3, 10'h50);
                wait_done("frz", st, cnt);
            end
            begin
                repeat (3) @(negedge clk);
                frz = {req_valid, resp_ready, mem_en, mem_we, cmd_ready,
                       done_valid, req_func, req_data0, 16'h0};
                clk_en = 0;
                repeat (4) @(negedge clk);
                check("frz_hold",
                      {req_valid, resp_ready, mem_en, mem_we, cmd_ready,
                       done_valid, req_func, req_data0, 16'h0}, frz);
                check("frz_wait", 64'(resp_ready), 64'd1);
                clk_en = 1;
            end
        join
        check("frz_st", 64'(st), 64'(CFU_OK));
        check("frz_cnt", 64'(cnt), 64'd2);
        check_log("frz");
        check("frz_m0", 64'(ram[10'h50]), 64'h43);
        check("frz_m1", 64'(ram[10'h51]), 64'h77);

        // Error on the second read_state response
        arm();
        rsp(CFU_OK, 32'h000000C3);
        rsp(CFU_OK, 32'hA);
        rsp(CFU_ERROR_STATE, 32'h0);
        exp_q.push_back(rq(2'd1, 2'd2, 1023, 0));
        exp_q.push_back(rq(2'd1, 2'd2, 1021, 0));
        exp_q.push_back(rq(2'd1, 2'd2, 1021, 1));
        send_cmd(1, 2'd1, 2'd2, 10'h60);
        wait_done("err", st, cnt);
        check("err_st", 64'(st), 64'(CFU_ERROR_STATE));
        check("err_cnt", 64'(cnt), 64'd2);
        check_log("err");
        repeat (10) @(negedge clk);
        check("err_quiet", 64'(log_q.size()), 64'd3);
        check_ram4("err", 10'h60, 32'hC3, 32'hA, 32'hDEAD0062, 32'hDEAD0063);

        // Reset in the middle of a save
        arm(); script_n3();
        send_cmd(1, 2'd1, 2'd2, 10'h70);
        for (int k = 0; k < 200 && log_q.size() < 3; k++) @(negedge clk);
        check("mrst_reach", 64'(log_q.size()), 64'd3);
        rst_n = 0;
        wr0 = mem_wr_cnt;
        repeat (2) @(negedge clk);
        check_idle_outs("mrst");
        rst_n = 1;
        repeat (10) @(negedge clk);
        check("mrst_noreq", 64'(log_q.size()), 64'd3);
        check("mrst_nowr", 64'(mem_wr_cnt - wr0), 64'd0);
        check("mrst_part", 64'(ram[10'h72]), 64'hDEAD0072);

        arm(); script_n3(); exp_save_n3(2'd2, 2'd1);
        send_cmd(1, 2'd2, 2'd1, 10'h80);
        wait_done("fresh", st, cnt);
        check("fresh_st", 64'(st), 64'(CFU_OK));
        check("fresh_cnt", 64'(cnt), 64'd4);
        check_log("fresh");
        check_ram4("fresh", 10'h80, 32'hC3, 32'hA, 32'hB, 32'hC);

        // Address wrap at the top of the RAM
        arm(); script_n3(); exp_save_n3(2'd2, 2'd3);
        send_cmd(1, 2'd2, 2'd3, 10'h3FE);
        wait_done("wrap", st, cnt);
        check("wrap_cnt", 64'(cnt), 64'd4);
        check_log("wrap");
        check_ram4("wrap", 10'h3FE, 32'hC3, 32'hA, 32'hB, 32'hC);

        arm();
        repeat (4) rsp(CFU_OK, 32'h0);
        exp_restore_n3(2'd2, 2'd3);
        send_cmd(0, 2'd2, 2'd3, 10'h3FE);
        wait_done("wrst", st, cnt);
        check("wrst_st", 64'(st), 64'(CFU_OK));
        check("wrst_cnt", 64'(cnt), 64'd4);
        check_log("wrst");

        repeat (2) @(negedge clk);
        check("end_idle", 64'(cmd_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
